// File: rtl/temp_uart_pkg.sv
// Shared constants and types for the temperature-to-UART line reporter.
package temp_uart_pkg;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int FRAME_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_CONV,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 9-bit binary to three BCD digits in 9 shift cycles.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [8:0]  shift_reg;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [3:0]  count;

  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd[gi*4 +: 4] >= 4'd5) ? bcd[gi*4 +: 4] + 4'd3
                                                          : bcd[gi*4 +: 4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bcd       <= '0;
      count     <= '0;
    end else if (start) begin
      shift_reg <= bin;
      bcd       <= '0;
      count     <= 4'd9;
    end else if (count != 4'd0) begin
      {bcd, shift_reg} <= {bcd_adj[10:0], shift_reg, 1'b0};
      count            <= count - 4'd1;
    end
  end

  // High during the final shift cycle; digits are valid from the next cycle on.
  assign done     = (count == 4'd1);
  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign ones     = bcd[3:0];

endmodule

// File: rtl/temp_uart_reporter.sv
// Snapshots the sensor word, formats it as "+HTO.F\r\n" and streams it into a UART transmitter.
module temp_uart_reporter
  import temp_uart_pkg::*;
#(
  parameter int PERIOD_CYCLES = 100_000_000,
  parameter int CW            = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        trig,
  input  logic [15:0] temp_data,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        frame_done
);

  state_t      state;
  logic [CW-1:0] period_cnt;
  logic        wrap;
  logic        request;
  logic        pending;
  logic        sign;
  logic [3:0]  fdig;
  logic [2:0]  idx;
  logic [12:0] t;
  logic [12:0] mag;
  logic [7:0]  frac_x10;
  logic        bcd_start;
  logic        bcd_done;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic [7:0]  frame_byte;
  logic        unused_bits;

  assign wrap    = enable && (period_cnt == CW'(PERIOD_CYCLES - 1));
  assign request = trig || wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      period_cnt <= '0;
    else if (!enable || wrap)
      period_cnt <= '0;
    else
      period_cnt <= period_cnt + 1'b1;
  end

  // Magnitude is 13-bit unsigned so the most negative code -4096 maps to 4096.
  assign t         = temp_data[15:3];
  assign mag       = t[12] ? (~t + 13'd1) : t;
  assign frac_x10  = {4'd0, mag[3:0]} * 8'd10;
  assign bcd_start = (state == ST_SNAP);
  assign unused_bits = ^{temp_data[2:0], frac_x10[3:0]};

  bin2bcd_seq u_bcd (
    .clk      (clk),
    .reset    (reset),
    .start    (bcd_start),
    .bin      (mag[12:4]),
    .done     (bcd_done),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  always_comb begin
    frame_byte = ASCII_LF;
    case (idx)
      3'd0: frame_byte = sign ? ASCII_MINUS : ASCII_PLUS;
      3'd1: frame_byte = (hundreds == 4'd0) ? ASCII_SPACE : (ASCII_ZERO | {4'd0, hundreds});
      3'd2: frame_byte = (hundreds == 4'd0 && tens == 4'd0) ? ASCII_SPACE
                                                             : (ASCII_ZERO | {4'd0, tens});
      3'd3: frame_byte = ASCII_ZERO | {4'd0, ones};
      3'd4: frame_byte = ASCII_DOT;
      3'd5: frame_byte = ASCII_ZERO | {4'd0, fdig};
      3'd6: frame_byte = ASCII_CR;
      default: frame_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      sign       <= 1'b0;
      fdig       <= 4'd0;
      idx        <= 3'd0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      // One-deep request memory while a frame is in flight.
      if (request && state != ST_IDLE)
        pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (request || pending) begin
            state   <= ST_SNAP;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        ST_SNAP: begin
          sign  <= t[12];
          fdig  <= frac_x10[7:4];
          idx   <= 3'd0;
          state <= ST_CONV;
        end
        ST_CONV: begin
          if (bcd_done)
            state <= ST_SEND;
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_data  <= frame_byte;
            tx_start <= 1'b1;
            state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (tx_busy)
            state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (idx == 3'(FRAME_LEN - 1)) begin
              state <= ST_FINISH;
            end else begin
              idx   <= idx + 3'd1;
              state <= ST_SEND;
            end
          end
        end
        ST_FINISH: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
